ulbf_master: RTL and testbench

ULBF_MASTER -- requirements
Module: ulbf_master

---
 rtl/ulbf_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_ulbf_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulbf_master.sv
// ulbf_master: RAM-backed AXI4-Stream transmit master.
// A host fills the transmit buffer through the load port. A run replays words
// 0..block_len-1 as niter packets on the stream port, with tlast closing each packet.
module ulbf_master #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned RAM_DEPTH   = 1536,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  // Load port
  input  logic                   ld_en,
  input  logic                   ld_we,
  input  logic [15:0]            ld_addr,
  input  logic [TDATA_WIDTH-1:0] ld_din,
  output logic [TDATA_WIDTH-1:0] ld_dout,
  // Run control and status
  input  logic                   start,
  input  logic [15:0]            block_len,
  input  logic [11:0]            niter,
  output logic                   busy,
  output logic                   txdone,
  output logic [3:0]             current_state,
  output logic [15:0]            txram_counter,
  // AXI4-Stream master
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast
);

  localparam int unsigned AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [15:0] DepthLen = 16'(RAM_DEPTH);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StPrefetch = 4'd1,
    StStream   = 4'd2,
    StDone     = 4'd3
  } state_e;

  // Control state
  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        txdone_q, txdone_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;

  // Read pointer: next word to fetch and packets still to fetch
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [11:0] rd_pkt_q, rd_pkt_d;
  logic        reads_done_q, reads_done_d;

  // Two-entry skid: rd holds the RAM read register, sk holds the older word
  logic                   rd_v_q, rd_v_d;
  logic                   rd_last_q, rd_last_d;
  logic                   rd_final_q, rd_final_d;
  logic [TDATA_WIDTH-1:0] rd_data_q;
  logic                   sk_v_q, sk_v_d;
  logic                   sk_last_q, sk_last_d;
  logic                   sk_final_q, sk_final_d;
  logic [TDATA_WIDTH-1:0] sk_data_q, sk_data_d;

  logic [TDATA_WIDTH-1:0] ld_dout_q;
  logic [TDATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic idle_like, start_ok, ld_in_range, ld_wr;
  logic out_valid, out_final, fire, issue, rd_addr_last;

  assign idle_like    = (state_q == StIdle) || (state_q == StDone);
  assign start_ok     = idle_like && start && (block_len != 16'd0);
  assign ld_in_range  = ld_addr < DepthLen;
  assign ld_wr        = ld_en && ld_we && ld_in_range && idle_like;
  assign out_valid    = sk_v_q | rd_v_q;
  assign out_final    = sk_v_q ? sk_final_q : rd_final_q;
  assign fire         = out_valid & m_axis_tready;
  assign rd_addr_last = rd_addr_q == (len_q - 16'd1);
  // Fetch whenever at least one skid slot is free; this sustains one beat per cycle
  // without looking at tready.
  assign issue        = ((state_q == StPrefetch) || (state_q == StStream)) &&
                        !reads_done_q && !(sk_v_q && rd_v_q);

  // Buffer write port; contents deliberately survive reset
  always_ff @(posedge s_axi_aclk) begin
    if (ld_wr) begin
      mem_q[ld_addr[AW-1:0]] <= ld_din;
    end
  end

  // Buffer read registers, kept next to the array so it maps onto a synchronous RAM
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_data_q <= '0;
      ld_dout_q <= '0;
    end else begin
      if (issue) begin
        rd_data_q <= mem_q[rd_addr_q[AW-1:0]];
      end
      if (ld_en) begin
        ld_dout_q <= ld_in_range ? mem_q[ld_addr[AW-1:0]] : '0;
      end
    end
  end

  // Next-state logic for the run FSM, read pointer and skid buffer
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    txdone_d     = txdone_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    rd_addr_d    = rd_addr_q;
    rd_pkt_d     = rd_pkt_q;
    reads_done_d = reads_done_q;
    rd_v_d       = rd_v_q;
    rd_last_d    = rd_last_q;
    rd_final_d   = rd_final_q;
    sk_v_d       = sk_v_q;
    sk_last_d    = sk_last_q;
    sk_final_d   = sk_final_q;
    sk_data_d    = sk_data_q;

    // Skid movement: the head (sk if valid, else rd) leaves on fire; a new fetch
    // always lands in rd, so any surviving rd word shifts into sk first.
    if (fire) begin
      sk_v_d = sk_v_q & rd_v_q;
      if (sk_v_q && rd_v_q) begin
        sk_data_d  = rd_data_q;
        sk_last_d  = rd_last_q;
        sk_final_d = rd_final_q;
      end
      rd_v_d = 1'b0;
    end else if (issue && rd_v_q) begin
      sk_v_d     = 1'b1;
      sk_data_d  = rd_data_q;
      sk_last_d  = rd_last_q;
      sk_final_d = rd_final_q;
    end

    if (issue) begin
      rd_v_d     = 1'b1;
      rd_last_d  = rd_addr_last;
      rd_final_d = rd_addr_last && (rd_pkt_q == 12'd1);
      if (rd_addr_last) begin
        rd_addr_d = 16'd0;
        rd_pkt_d  = rd_pkt_q - 12'd1;
        if (rd_pkt_q == 12'd1) begin
          reads_done_d = 1'b1;
        end
      end else begin
        rd_addr_d = rd_addr_q + 16'd1;
      end
    end

    if (fire && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          len_d     = (block_len > DepthLen) ? DepthLen : block_len;
          rd_addr_d = 16'd0;
          rd_pkt_d  = niter;
          cnt_d     = 16'd0;
          if (niter == 12'd0) begin
            reads_done_d = 1'b1;
            busy_d       = 1'b0;
            txdone_d     = 1'b1;
            state_d      = StDone;
          end else begin
            reads_done_d = 1'b0;
            busy_d       = 1'b1;
            txdone_d     = 1'b0;
            state_d      = StPrefetch;
          end
        end
      end
      StPrefetch: begin
        state_d = StStream;
      end
      StStream: begin
        if (fire && out_final) begin
          busy_d   = 1'b0;
          txdone_d = 1'b1;
          state_d  = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and skid registers; reset drops any in-flight beat
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      txdone_q     <= 1'b0;
      cnt_q        <= 16'd0;
      len_q        <= 16'd0;
      rd_addr_q    <= 16'd0;
      rd_pkt_q     <= 12'd0;
      reads_done_q <= 1'b1;
      rd_v_q       <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_final_q   <= 1'b0;
      sk_v_q       <= 1'b0;
      sk_last_q    <= 1'b0;
      sk_final_q   <= 1'b0;
      sk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      txdone_q     <= txdone_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      rd_addr_q    <= rd_addr_d;
      rd_pkt_q     <= rd_pkt_d;
      reads_done_q <= reads_done_d;
      rd_v_q       <= rd_v_d;
      rd_last_q    <= rd_last_d;
      rd_final_q   <= rd_final_d;
      sk_v_q       <= sk_v_d;
      sk_last_q    <= sk_last_d;
      sk_final_q   <= sk_final_d;
      sk_data_q    <= sk_data_d;
    end
  end

  assign ld_dout       = ld_dout_q;
  assign busy          = busy_q;
  assign txdone        = txdone_q;
  assign current_state = state_q;
  assign txram_counter = cnt_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = sk_v_q ? sk_data_q : (rd_v_q ? rd_data_q : '0);
  assign m_axis_tlast  = sk_v_q ? sk_last_q : (rd_v_q & rd_last_q);
  assign m_axis_tkeep  = {TKEEP_WIDTH{out_valid}};

endmodule

// File: tb/tb_ulbf_master.sv
// Randomised bench for ulbf_master: a buffer image plus an expected-beat queue
// built from block_len/niter, with every stream handshake checked against it.
module tb_ulbf_master;

  localparam int W     = 64;
  localparam int DEPTH = 1536;
  localparam int KW    = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_en, ld_we;
  logic [15:0]   ld_addr;
  logic [W-1:0]  ld_din, ld_dout;
  logic          start;
  logic [15:0]   block_len;
  logic [11:0]   niter;
  logic          busy, txdone;
  logic [3:0]    current_state;
  logic [15:0]   txram_counter;
  logic          tvalid, tready, tlast;
  logic [W-1:0]  tdata;
  logic [KW-1:0] tkeep;

  always #5 clk = ~clk;

  ulbf_master #(
    .TDATA_WIDTH(W),
    .RAM_DEPTH  (DEPTH),
    .TKEEP_WIDTH(KW)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .ld_en        (ld_en),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_din       (ld_din),
    .ld_dout      (ld_dout),
    .start        (start),
    .block_len    (block_len),
    .niter        (niter),
    .busy         (busy),
    .txdone       (txdone),
    .current_state(current_state),
    .txram_counter(txram_counter),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tlast (tlast)
  );

  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_data [$];
  logic         exp_last [$];
  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;
  int rdy_base = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tready: 0 = always high, 1 = random, 2 = 1010 toggle with a 3-cycle stall
  initial begin
    int k;
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k = cyc - rdy_base;
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom % 3) != 0;
        default: tready = (k >= 9 && k <= 11) ? 1'b0 : (k % 2 == 0);
      endcase
    end
  end

  // Stream monitor: ordering against the expected queue and stability under stall
  logic         pv = 1'b0, pr = 1'b0, plast = 1'b0;
  logic [W-1:0] pdata = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 64'(tvalid), 64'd1);
        check("hold_data", tdata, pdata);
        check("hold_last", 64'(tlast), 64'(plast));
      end
      if (tvalid && tready) begin
        check("tkeep", 64'(tkeep), 64'hFF);
        check("beat_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) begin
          check("beat_data", tdata, exp_data.pop_front());
          check("beat_last", 64'(tlast), 64'(exp_last.pop_front()));
        end
      end
      pv = tvalid; pr = tready; pdata = tdata; plast = tlast;
    end
  end

  // All tasks are entered and left at posedge+1
  task automatic wr(input logic [15:0] a, input logic [W-1:0] d, input bit upd);
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = a; ld_din = d;
    if (upd && a < DEPTH) ref_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0; ld_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [W-1:0] exp);
    ld_en = 1'b1; ld_we = 1'b0; ld_addr = a;
    @(posedge clk); #1;
    ld_en = 1'b0;
    check("ld_dout", ld_dout, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_state"}, 64'(current_state), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_txdone"}, 64'(txdone), 64'd0);
    check({tag, "_cnt"}, 64'(txram_counter), 64'd0);
    check({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(tlast), 64'd0);
    check({tag, "_tkeep"}, 64'(tkeep), 64'd0);
    check({tag, "_tdata"}, tdata, 64'd0);
    check({tag, "_ld_dout"}, ld_dout, 64'd0);
  endtask

  // poke: 1 = start while busy, 2 = load write mid-stream, 3 = reset mid-run
  task automatic run(input int len, input int nit, input int mode, input int poke);
    int eff, nbeats, bound;
    eff    = (len > DEPTH) ? DEPTH : len;
    nbeats = eff * nit;
    for (int p = 0; p < nit; p++) begin
      for (int i = 0; i < eff; i++) begin
        exp_data.push_back(ref_mem[i]);
        exp_last.push_back(i == eff - 1);
      end
    end
    rdy_mode = mode;
    rdy_base = cyc;
    start = 1'b1; block_len = len[15:0]; niter = nit[11:0];
    @(posedge clk); #1;
    start = 1'b0; block_len = 16'($urandom); niter = 12'($urandom);
    if (nit == 0) begin
      check("n0_txdone", 64'(txdone), 64'd1);
      check("n0_state", 64'(current_state), 64'd3);
      check("n0_busy", 64'(busy), 64'd0);
      check("n0_cnt", 64'(txram_counter), 64'd0);
      @(posedge clk); #1;
      check("n0_tvalid", 64'(tvalid), 64'd0);
      return;
    end
    check("pf_state", 64'(current_state), 64'd1);
    check("pf_busy", 64'(busy), 64'd1);
    check("pf_txdone", 64'(txdone), 64'd0);
    check("pf_tvalid", 64'(tvalid), 64'd0);
    @(posedge clk); #1;
    check("st_state", 64'(current_state), 64'd2);
    check("st_tvalid", 64'(tvalid), 64'd1);
    bound = nbeats * 6 + 40;
    for (int c = 0; c < bound && !txdone; c++) begin
      if (poke == 1 && c == 3) begin
        start = 1'b1; block_len = 16'd7; niter = 12'd9;
      end
      if (poke == 2 && c == 3) begin
        ld_en = 1'b1; ld_we = 1'b1; ld_addr = 16'd5; ld_din = 64'hDEAD_BEEF;
      end
      if (poke == 3 && c == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        exp_data.delete();
        exp_last.delete();
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0; ld_en = 1'b0; ld_we = 1'b0;
    end
    check("end_txdone", 64'(txdone), 64'd1);
    check("end_state", 64'(current_state), 64'd3);
    check("end_busy", 64'(busy), 64'd0);
    check("end_tvalid", 64'(tvalid), 64'd0);
    check("end_cnt", 64'(txram_counter), 64'(nbeats));
    check("end_left", 64'(exp_data.size()), 64'd0);
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_din = '0;
    start = 1'b0; block_len = '0; niter = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst");

    // block_len=0 presented on the first edge after release: ignored
    rst_n = 1'b1;
    start = 1'b1; block_len = 16'd0; niter = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("bl0_state", 64'(current_state), 64'd0);
    check("bl0_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("bl0_state2", 64'(current_state), 64'd0);

    // Fill the whole buffer with random words
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_we = 1'b1; ld_addr = 16'(i); ld_din = {$urandom, $urandom};
      ref_mem[i] = ld_din;
      @(posedge clk); #1;
    end
    ld_en = 1'b0; ld_we = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'(i), 64'h10 + 64'(i), 1'b1);
    rd(16'd2, 64'h12);
    rd(16'd2000, 64'd0);
    rd(16'd1535, ref_mem[1535]);
    wr(16'h8005, 64'h5555_AAAA, 1'b0);
    rd(16'd5, ref_mem[5]);

    run(4, 2, 0, 0);
    run(4, 2, 2, 0);
    wr(16'd0, 64'hAB, 1'b1);
    run(1, 3, 0, 0);

    // block_len=0 in DONE: ignored, stays done
    start = 1'b1; block_len = 16'd0; niter = 12'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("bl0d_state", 64'(current_state), 64'd3);
    check("bl0d_txdone", 64'(txdone), 64'd1);

    run(4, 0, 0, 0);
    run(5, 3, 0, 1);
    run(6, 2, 1, 2);
    rd(16'd5, ref_mem[5]);
    run(2000, 1, 0, 0);
    for (int r = 0; r < 5; r++) begin
      run(int'($urandom_range(1, 24)), int'($urandom_range(1, 4)),
          int'($urandom_range(0, 2)), 0);
    end

    run(8, 3, 0, 3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(4, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
